// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multicycle fetch/decode/execute controller around an external ALU
`timescale 1ns/1ps
module alu_sequencer #(
  parameter logic [19:0] RESET_VECTOR = 20'h00000,
  parameter logic [19:0] TRAP_VECTOR  = 20'h00100
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [19:0] imem_addr,
  input  logic        imem_ack,
  input  logic [19:0] imem_rdata,
  output logic [4:0]  alu_op,
  output logic [19:0] alu_a,
  output logic [19:0] alu_b,
  output logic        alu_cin,
  output logic [3:0]  alu_shamt,
  input  logic [19:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        alu_cout,
  output logic [19:0] pp,
  output logic [19:0] status,
  output logic        trap_mode,
  output logic        instr_done,
  input  logic [3:0]  dbg_sel,
  output logic [19:0] dbg_data
);

  localparam logic [4:0] OP_TRAP  = 5'd1;
  localparam logic [4:0] OP_JMP   = 5'd2;
  localparam logic [4:0] OP_JMPZ  = 5'd3;
  localparam logic [4:0] OP_JMPS  = 5'd4;
  localparam logic [4:0] OP_JMPZS = 5'd5;
  localparam logic [4:0] OP_LSTAT = 5'd6;
  localparam logic [4:0] OP_XSTAT = 5'd7;
  localparam logic [4:0] OP_SWAP  = 5'd16;
  localparam logic [4:0] OP_ADDC  = 5'd20;
  localparam logic [4:0] OP_LDI   = 5'd27;

  typedef enum logic [1:0] {S_FETCH, S_FETCH2, S_EXEC, S_SWAP2} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [19:0] r_pp;
  logic [19:0] r_word2;
  logic [19:0] r_hold;
  logic [4:0]  r_op;
  logic [3:0]  r_rd;
  logic [3:0]  r_rs;
  logic [3:0]  r_shamt;
  logic [19:0] r_regs [16];
  logic        r_zero;
  logic        r_sign;
  logic        r_carry;
  logic        r_trap;

  logic [19:0] w_rd_val;
  logic [19:0] w_rs_val;
  logic [19:0] w_status;
  logic [19:0] w_pp_next;
  logic [19:0] w_wdata;
  logic [3:0]  w_waddr;
  logic        w_we;
  logic        w_zero_next;
  logic        w_sign_next;
  logic        w_carry_next;
  logic        w_trap_next;
  logic        w_is_alu;
  logic        w_is_cmp;
  logic        w_take;

  function automatic logic is_two_word(input logic [4:0] op);
    return ((op >= OP_JMP) && (op <= OP_JMPZS)) || (op == OP_LDI);
  endfunction

  assign w_rd_val  = r_regs[r_rd];
  assign w_rs_val  = r_regs[r_rs];
  assign w_status  = {16'h0000, r_trap, r_carry, r_sign, r_zero};
  // SWAP sits inside the ALU opcode range but is handled by the controller
  assign w_is_alu  = (r_op >= 5'd8) && (r_op <= 5'd21) && (r_op != OP_SWAP);
  assign w_is_cmp  = (r_op >= 5'd22) && (r_op <= 5'd26);
  assign status    = w_status;
  assign trap_mode = r_trap;
  assign pp        = r_pp;
  assign imem_addr = r_pp;
  assign dbg_data  = r_regs[dbg_sel];

  // jump condition from the flags left by earlier instructions
  always_comb begin
    w_take = 1'b0;
    case (r_op)
      OP_JMP:   w_take = 1'b1;
      OP_JMPZ:  w_take = r_zero;
      OP_JMPS:  w_take = r_sign;
      OP_JMPZS: w_take = r_sign & r_zero;
      default:  w_take = 1'b0;
    endcase
  end

  // next state, fetch port, ALU drive and the single register-file write port
  always_comb begin
    w_next_state = r_state;
    w_pp_next    = r_pp;
    imem_req     = 1'b0;
    instr_done   = 1'b0;
    alu_op       = 5'd0;
    alu_a        = 20'd0;
    alu_b        = 20'd0;
    alu_cin      = 1'b0;
    alu_shamt    = 4'd0;
    w_we         = 1'b0;
    w_waddr      = r_rd;
    w_wdata      = alu_result;
    w_zero_next  = r_zero;
    w_sign_next  = r_sign;
    w_carry_next = r_carry;
    w_trap_next  = r_trap;
    // reset abandons whatever is in flight, so nothing is requested or retired
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            w_pp_next    = r_pp + 20'd1;
            w_next_state = is_two_word(imem_rdata[19:15]) ? S_FETCH2 : S_EXEC;
          end
        end
        S_FETCH2: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            w_pp_next    = r_pp + 20'd1;
            w_next_state = S_EXEC;
          end
        end
        S_EXEC: begin
          if ((r_op >= 5'd8) && (r_op <= 5'd26)) alu_op = r_op;
          alu_a        = w_rd_val;
          alu_b        = w_rs_val;
          alu_cin      = r_carry;
          alu_shamt    = r_shamt;
          instr_done   = (r_op != OP_SWAP);
          w_next_state = (r_op == OP_SWAP) ? S_SWAP2 : S_FETCH;
          if (w_is_alu) begin
            w_we        = 1'b1;
            w_wdata     = alu_result;
            w_zero_next = (alu_result == 20'd0);
            w_sign_next = alu_result[19];
            if (r_op == OP_ADDC) w_carry_next = alu_cout;
          end else if (w_is_cmp) begin
            w_zero_next = alu_zero;
            w_sign_next = alu_sign;
          end else begin
            case (r_op)
              OP_TRAP: begin
                w_trap_next = 1'b1;
                w_pp_next   = TRAP_VECTOR;
              end
              OP_JMP, OP_JMPZ, OP_JMPS, OP_JMPZS: begin
                if (w_take) w_pp_next = r_word2;
              end
              OP_LSTAT: begin
                w_we    = 1'b1;
                w_wdata = w_status;
              end
              OP_XSTAT: begin
                w_we    = r_trap;
                w_wdata = w_status ^ w_rd_val;
              end
              OP_SWAP: begin
                w_we    = 1'b1;
                w_wdata = w_rs_val;
              end
              OP_LDI: begin
                w_we    = 1'b1;
                w_wdata = r_word2;
              end
              default: begin
                // NOP lands here too; only 28-31 are illegal
                if (r_op >= 5'd28) begin
                  w_trap_next = 1'b1;
                  w_pp_next   = TRAP_VECTOR;
                end
              end
            endcase
          end
        end
        S_SWAP2: begin
          instr_done   = 1'b1;
          w_we         = 1'b1;
          w_waddr      = r_rs;
          w_wdata      = r_hold;
          w_next_state = S_FETCH;
        end
        default: w_next_state = S_FETCH;
      endcase
    end
  end

  // architectural state, register file and latched instruction fields
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pp    <= RESET_VECTOR;
      r_zero  <= 1'b0;
      r_sign  <= 1'b0;
      r_carry <= 1'b0;
      r_trap  <= 1'b0;
      r_op    <= 5'd0;
      r_rd    <= 4'd0;
      r_rs    <= 4'd0;
      r_shamt <= 4'd0;
      r_word2 <= 20'd0;
      r_hold  <= 20'd0;
      for (int i = 0; i < 16; i++) r_regs[i] <= 20'd0;
    end else begin
      r_state <= w_next_state;
      r_pp    <= w_pp_next;
      r_zero  <= w_zero_next;
      r_sign  <= w_sign_next;
      r_carry <= w_carry_next;
      r_trap  <= w_trap_next;
      if (w_we) r_regs[w_waddr] <= w_wdata;
      if ((r_state == S_FETCH) && imem_ack) begin
        r_op    <= imem_rdata[19:15];
        r_rd    <= imem_rdata[14:11];
        r_rs    <= imem_rdata[10:7];
        r_shamt <= imem_rdata[3:0];
      end
      if ((r_state == S_FETCH2) && imem_ack) r_word2 <= imem_rdata;
      // SWAP2 needs the destination's value from before the EXEC write
      if ((r_state == S_EXEC) && (r_op == OP_SWAP)) r_hold <= w_rd_val;
    end
  end

endmodule
